// File: rtl/two_par_pkg.sv
// Shared definitions for the two-sample parallel filter output path:
// default widths, output phase encoding and the requantize/saturate helper.
package two_par_pkg;

   localparam int DEF_IN_W  = 64;
   localparam int DEF_OUT_W = 16;
   localparam int DEF_SHIFT = 15;

   // Working width of the requantizer; callers sign-extend into it.
   localparam int RQ_W = 128;

   typedef enum logic {
      PH0 = 1'b0,
      PH1 = 1'b1
   } phase_e;

   typedef struct packed {
      logic signed [RQ_W-1:0] value;
      logic                   clipped;
   } rq_t;

   // Round half up by adding 2^(shift-1), arithmetic shift right, then clip
   // to the signed out_w range. One guard bit keeps the add from overflowing.
   function automatic rq_t requant_sat(input logic signed [RQ_W-1:0] x,
                                       input int unsigned shift,
                                       input int unsigned out_w);
      logic        [RQ_W:0] one;
      logic signed [RQ_W:0] wide;
      logic signed [RQ_W:0] hi;
      logic signed [RQ_W:0] lo;
      rq_t                  r;
      one  = {{RQ_W{1'b0}}, 1'b1};
      wide = {x[RQ_W-1], x};
      if (shift != 0) begin
         wide = wide + signed'(one << (shift - 1));
      end
      wide = wide >>> shift;
      hi   = signed'((one << (out_w - 1)) - one);
      lo   = ~hi;
      r.value   = wide[RQ_W-1:0];
      r.clipped = 1'b0;
      if (wide > hi) begin
         r.value   = hi[RQ_W-1:0];
         r.clipped = 1'b1;
      end else if (wide < lo) begin
         r.value   = lo[RQ_W-1:0];
         r.clipped = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pair_fifo.sv
// DEPTH-entry FIFO of requantized sample pairs. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module pair_fifo
   import two_par_pkg::*;
#(
   parameter int W     = DEF_OUT_W,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic signed [W-1:0] wdata1,
   input  logic signed [W-1:0] wdata2,
   input  logic                pop,
   output logic signed [W-1:0] rdata1,
   output logic signed [W-1:0] rdata2,
   output logic                empty,
   output logic                full_nxt
);

   localparam int AW = $clog2(DEPTH);

   logic        [AW:0] wptr_q, wptr_d;
   logic        [AW:0] rptr_q, rptr_d;
   logic signed [W-1:0] mem1_q [DEPTH];
   logic signed [W-1:0] mem2_q [DEPTH];

   // Next pointer values; wrap falls out of the AW+1 bit arithmetic.
   always_comb begin
      wptr_d = wptr_q + (AW+1)'(push);
      rptr_d = rptr_q + (AW+1)'(pop);
   end

   // Pointer registers, cleared by reset so buffered pairs are discarded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Pair storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem1_q[wptr_q[AW-1:0]] <= wdata1;
         mem2_q[wptr_q[AW-1:0]] <= wdata2;
      end
   end

   assign rdata1   = mem1_q[rptr_q[AW-1:0]];
   assign rdata2   = mem2_q[rptr_q[AW-1:0]];
   assign empty    = (wptr_q == rptr_q);
   assign full_nxt = (wptr_d[AW] != rptr_d[AW]) &&
                     (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

endmodule

// File: rtl/two_par_serializer.sv
// Turns pairs of wide parallel filter outputs into a serial stream of
// requantized samples: din1 of each pair is emitted before din2.
module two_par_serializer
   import two_par_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int SHIFT = DEF_SHIFT,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  din1,
   input  logic signed [IN_W-1:0]  din2,
   output logic signed [OUT_W-1:0] dout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             sat_count
);

   rq_t                    rq1, rq2;
   logic signed [OUT_W-1:0] q1, q2;
   logic signed [OUT_W-1:0] rd1, rd2;
   logic                    push, pop, empty, full_nxt;
   logic                    in_ready_q;
   logic [15:0]             sat_q, sat_d;
   logic [16:0]             sat_sum;
   phase_e                  phase_q, phase_d;
   logic                    unused_hi;

   // Requantize both samples of the presented pair before they are stored.
   always_comb begin
      rq1 = requant_sat(RQ_W'(din1), SHIFT, OUT_W);
      rq2 = requant_sat(RQ_W'(din2), SHIFT, OUT_W);
      q1  = rq1.value[OUT_W-1:0];
      q2  = rq2.value[OUT_W-1:0];
   end

   assign unused_hi = ^{rq1.value[RQ_W-1:OUT_W], rq2.value[RQ_W-1:OUT_W]};

   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready & (phase_q == PH1);
   assign out_valid = ~empty;
   assign in_ready  = in_ready_q;
   assign sat_count = sat_q;

   pair_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .wdata1   (q1),
      .wdata2   (q2),
      .pop      (pop),
      .rdata1   (rd1),
      .rdata2   (rd2),
      .empty    (empty),
      .full_nxt (full_nxt)
   );

   // Output phase next-state and head-element select; dout is zero when idle.
   always_comb begin
      phase_d = phase_q;
      dout    = '0;
      if (out_valid) begin
         dout = (phase_q == PH1) ? rd2 : rd1;
         if (out_ready) begin
            phase_d = (phase_q == PH0) ? PH1 : PH0;
         end
      end
   end

   // Clip counter next value, sticking at all-ones.
   always_comb begin
      sat_sum = {1'b0, sat_q};
      if (push) begin
         sat_sum = sat_sum + 17'(rq1.clipped) + 17'(rq2.clipped);
      end
      sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

   // Output phase state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= PH0;
      end else begin
         phase_q <= phase_d;
      end
   end

   // in_ready is registered from next-cycle fullness, so out_ready never
   // reaches it combinationally; a pop from full reopens it one edge later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_q <= 1'b0;
         sat_q      <= '0;
      end else begin
         in_ready_q <= ~full_nxt;
         sat_q      <= sat_d;
      end
   end

endmodule

// File: tb/tb_two_par_serializer.sv
// Bench for two_par_serializer: directed scenarios plus random traffic,
// every cycle compared against a sample-queue reference model.
module tb_two_par_serializer;

   localparam int IN_W  = 64;
   localparam int OUT_W = 16;
   localparam int SHIFT = 15;
   localparam int DEPTH = 4;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic signed [IN_W-1:0]  din1 = '0;
   logic signed [IN_W-1:0]  din2 = '0;
   logic signed [OUT_W-1:0] dout;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [15:0]             sat_count;

   two_par_serializer #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din1      (din1),
      .din2      (din2),
      .dout      (dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queue of samples still to be emitted, in output order.
   int exp_q[$];
   int got_q[$];
   int sat_exp = 0;
   bit rdy_exp = 1'b0;

   function automatic int ref_rq(input logic signed [IN_W-1:0] x, output bit clip);
      logic signed [IN_W:0] w;
      w    = x;
      w    = w + (1 <<< (SHIFT - 1));
      w    = w >>> SHIFT;
      clip = 1'b0;
      if (w > 32767) begin
         clip = 1'b1;
         return 32767;
      end
      if (w < -32768) begin
         clip = 1'b1;
         return -32768;
      end
      return int'(w);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_out_valid"}, out_valid, (exp_q.size() > 0) ? 1 : 0);
      chk({tag, "_dout"}, dout, (exp_q.size() > 0) ? exp_q[0] : 0);
      chk({tag, "_in_ready"}, in_ready, rdy_exp);
      chk({tag, "_sat_count"}, sat_count, sat_exp);
   endtask

   // One clock: predict transfers from pre-edge inputs, step, then compare.
   task automatic cycle();
      bit                      ox, ix, dut_ox, c1, c2;
      logic signed [IN_W-1:0]  d1, d2;
      logic signed [OUT_W-1:0] seen;
      int                      a, b;
      ox     = (exp_q.size() > 0) && out_ready;
      ix     = in_valid && rdy_exp;
      dut_ox = out_valid && out_ready;
      d1     = din1;
      d2     = din2;
      seen   = dout;
      @(posedge clk);
      #1;
      if (dut_ox) got_q.push_back(int'(seen));
      if (ox) void'(exp_q.pop_front());
      if (ix) begin
         a = ref_rq(d1, c1);
         b = ref_rq(d2, c2);
         exp_q.push_back(a);
         exp_q.push_back(b);
         sat_exp = sat_exp + int'(c1) + int'(c2);
         if (sat_exp > 65535) sat_exp = 65535;
      end
      rdy_exp = ((exp_q.size() + 1) / 2) < DEPTH;
      check_outputs("cyc");
   endtask

   // Asynchronous reset away from the clock edge; released on a falling edge.
   task automatic apply_reset();
      #2;
      rst = 1'b0;
      #1;
      exp_q.delete();
      sat_exp = 0;
      rdy_exp = 1'b0;
      check_outputs("rst");
      @(negedge clk);
      rst = 1'b1;
      cycle();
      chk("rdy_after_rst", in_ready, 1);
   endtask

   function automatic logic signed [63:0] rnd_val();
      logic signed [63:0] v;
      int                 s;
      case ($urandom_range(0, 3))
         0: begin
            s = $urandom;
            v = s;
         end
         1: v = {$urandom, $urandom};
         2: begin
            v = 64'sd1073709056 + 64'($urandom_range(0, 65535)) - 64'sd32768;
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         default: v = ($urandom_range(0, 1) == 1) ? 64'h7FFF_FFFF_FFFF_FFFF
                                                  : 64'h8000_0000_0000_0000;
      endcase
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k, acc5_at, gaps, t, drain;
      bit  acc, started, ov;

      apply_reset();

      // Rounding: 0x8000 -> 1, 0x4000 -> 1 (half rounds up), then 0 and 0.
      out_ready = 1'b1;
      din1 = 64'sh8000;
      din2 = 64'sh4000;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("r032_a_d1", dout, 1);
      cycle();
      chk("r032_a_d2", dout, 1);
      cycle();
      din1 = 64'sh3FFF;
      din2 = -64'sh4000;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("r032_b_valid", out_valid, 1);
      chk("r032_b_d1", dout, 0);
      cycle();
      chk("r032_b_d2", dout, 0);
      cycle();

      // Saturation of both samples of one pair.
      chk("r033_sat_before", sat_count, 0);
      din1 = 64'sh100_0000_0000;
      din2 = -64'sh100_0000_0000;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("r033_d1", dout, 32767);
      chk("r033_sat_after", sat_count, 2);
      cycle();
      chk("r033_d2", dout, -32768);
      cycle();

      // Fill with out_ready low: four pairs fit, the fifth waits.
      out_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 20 && k < 4; i++) begin
         din1 = 64'(100 + 2 * k) <<< 15;
         din2 = 64'(101 + 2 * k) <<< 15;
         in_valid = 1'b1;
         acc = in_ready;
         cycle();
         if (acc) k++;
      end
      chk("r034_accepted4", k, 4);
      din1 = 64'(108) <<< 15;
      din2 = 64'(109) <<< 15;
      cycle();
      cycle();
      chk("r034_full_rdy", in_ready, 0);
      chk("r034_full_sat", sat_count, 2);
      out_ready = 1'b1;
      got_q.delete();
      acc5_at = -1;
      for (int i = 0; i < 40 && got_q.size() < 10; i++) begin
         acc = in_valid && in_ready;
         if (acc) acc5_at = got_q.size();
         cycle();
         if (acc) in_valid = 1'b0;
      end
      chk("r034_count", got_q.size(), 10);
      chk("r034_5th_after_pop", acc5_at, 2);
      for (int i = 0; i < 10; i++) begin
         chk("r034_order", (i < got_q.size()) ? got_q[i] : -1, 100 + i);
      end

      // Streaming ramp: one sample per clock with no gaps.
      got_q.delete();
      k = 0;
      gaps = 0;
      started = 1'b0;
      t = 0;
      while (t < 400 && got_q.size() < 128) begin
         din1 = 64'(2 * k) <<< 15;
         din2 = 64'(2 * k + 1) <<< 15;
         in_valid = (k < 64);
         acc = in_valid && in_ready;
         ov = out_valid;
         if (started && !ov) gaps++;
         if (ov) started = 1'b1;
         cycle();
         if (acc) k++;
         t++;
      end
      in_valid = 1'b0;
      chk("r035_pairs", k, 64);
      chk("r035_samples", got_q.size(), 128);
      chk("r035_gaps", gaps, 0);
      for (int i = 0; i < 128; i++) begin
         if (i < got_q.size()) chk("r035_ramp", got_q[i], i);
      end
      cycle();

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         din1 = rnd_val();
         din2 = rnd_val();
         cycle();
      end

      // Drain, then reset after din1 of a pair has left.
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain = 0;
      while (out_valid && drain < 50) begin
         cycle();
         drain++;
      end
      chk("drain_empty", out_valid, 0);
      din1 = 64'(5) <<< 15;
      din2 = 64'(6) <<< 15;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("r036_d1", dout, 5);
      cycle();
      chk("r036_d2_pending", dout, 6);
      apply_reset();
      chk("r036_valid", out_valid, 0);
      chk("r036_sat", sat_count, 0);
      din1 = 64'(7) <<< 15;
      din2 = 64'(8) <<< 15;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("r036_next_d1", dout, 7);
      cycle();
      chk("r036_next_d2", dout, 8);
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
